// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared types for the PC sequencer and its return-address stack
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

  typedef enum logic [1:0] {
    BRANCH = 2'd0,
    JUMP   = 2'd1,
    CALL   = 2'd2,
    RET    = 2'd3
  } redirect_e;

  // Widest PC the stack storage can hold; narrower PCs are zero-extended
  localparam int unsigned RAS_ENTRY_MAX_WIDTH = 64;

  typedef logic [RAS_ENTRY_MAX_WIDTH-1:0] ras_entry_t;

endpackage

`default_nettype wire

// File: rtl/pc_seq_if.sv
// ============================================================================
// Module      : pc_seq_if
// Description : Control/redirect inputs and PC/status outputs of the sequencer
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_seq_if
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             enable;
  logic             stall;
  logic             redirect_valid;
  redirect_e        redirect_kind;
  logic [WIDTH-1:0] redirect_target;
  logic             trap;
  logic [WIDTH-1:0] pc_out;
  logic             pc_valid;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output enable, stall, redirect_valid, redirect_kind, redirect_target, trap,
    input  pc_out, pc_valid, ras_overflow, ras_underflow
  );

  modport slave (
    input  enable, stall, redirect_valid, redirect_kind, redirect_target, trap,
    output pc_out, pc_valid, ras_overflow, ras_underflow
  );

endinterface

`default_nettype wire

// File: rtl/pc_ras.sv
// ============================================================================
// Module      : pc_ras
// Description : Circular return-address stack; a push when full drops the oldest
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ras
  import pc_seq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

  ras_entry_t       mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] ptr_inc;
  logic [CNT_W-1:0] count;

  // ptr names the next free slot; when full that slot holds the oldest entry
  assign top_idx = (ptr == '0) ? LAST_IDX : ptr - PTR_W'(1);
  assign ptr_inc = (ptr == LAST_IDX) ? '0 : ptr + PTR_W'(1);
  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign top     = WIDTH'(mem[top_idx]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr_inc;
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr   <= top_idx;
      count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= ras_entry_t'(push_data);
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer with trap, hold, redirect and step.
//               Define PC_SEQ_RAS_EN to build in the return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100),
  parameter int               STEP         = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic    clk,
  input  logic    rst,
  pc_seq_if.slave bus
);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] seq_pc;
  logic             advance;
  logic             valid;

  assign advance = bus.enable & ~bus.stall;
  assign seq_pc  = pc + WIDTH'(STEP);

`ifdef PC_SEQ_RAS_EN
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;
  logic             ovf;
  logic             unf;
  logic             ovf_next;
  logic             unf_next;

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (seq_pc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= ovf_next;
      unf <= unf_next;
    end
  end

  assign bus.ras_overflow  = ovf;
  assign bus.ras_underflow = unf;
`else
  assign bus.ras_overflow  = 1'b0;
  assign bus.ras_underflow = 1'b0;
`endif

  // Priority: trap, then hold, then redirect, then sequential step
  always_comb begin
    pc_next = pc;
`ifdef PC_SEQ_RAS_EN
    push     = 1'b0;
    pop      = 1'b0;
    ovf_next = 1'b0;
    unf_next = 1'b0;
`endif
    if (bus.trap) begin
      pc_next = TRAP_VECTOR;
    end else if (!advance) begin
      pc_next = pc;
    end else if (bus.redirect_valid) begin
      case (bus.redirect_kind)
`ifdef PC_SEQ_RAS_EN
        CALL: begin
          pc_next  = bus.redirect_target;
          push     = 1'b1;
          ovf_next = ras_full;
        end
        RET: begin
          if (!ras_empty) begin
            pc_next = ras_top;
            pop     = 1'b1;
          end else begin
            pc_next  = bus.redirect_target;
            unf_next = 1'b1;
          end
        end
`endif
        default: pc_next = bus.redirect_target;
      endcase
    end else begin
      pc_next = seq_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= RESET_VECTOR;
      valid <= 1'b0;
    end else begin
      pc    <= pc_next;
      valid <= 1'b1;
    end
  end

  assign bus.pc_out   = pc;
  assign bus.pc_valid = valid;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed self-checking bench for pc_sequencer (either build)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;
  import pc_seq_pkg::*;

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  pc_seq_if #(.WIDTH(32)) bus ();

  pc_sequencer #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .STEP         (4),
    .RAS_DEPTH    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic redir(input redirect_e kind, input logic [31:0] target);
    bus.redirect_valid  = 1'b1;
    bus.redirect_kind   = kind;
    bus.redirect_target = target;
  endtask

  initial begin
    logic [31:0] ret_exp [5];
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bus.enable = 1'b0;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_kind = BRANCH;
    bus.redirect_target = '0;
    bus.trap = 1'b0;

    tick();
    tick();
    chk("reset_pc", bus.pc_out, 32'h0);
    chk("reset_valid", bus.pc_valid, 1'b0);
    chk("reset_ovf", bus.ras_overflow, 1'b0);
    chk("reset_unf", bus.ras_underflow, 1'b0);

    rst = 1'b1;
    bus.enable = 1'b1;
    tick();
    chk("seq_pc4", bus.pc_out, 32'h4);
    chk("seq_valid", bus.pc_valid, 1'b1);
    tick();
    chk("seq_pc8", bus.pc_out, 32'h8);

    bus.stall = 1'b1;
    redir(BRANCH, 32'h80);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", bus.pc_out, 32'h8);
    end
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    tick();
    chk("seq_pcC", bus.pc_out, 32'hC);

    redir(JUMP, 32'h8);
    tick();
    chk("jump_8", bus.pc_out, 32'h8);
    redir(CALL, 32'h40);
    tick();
    chk("call_40", bus.pc_out, 32'h40);
    redir(RET, 32'h300);
    tick();
    chk("ret_C", bus.pc_out, RAS ? 32'hC : 32'h300);
    chk("ret_no_unf", bus.ras_underflow, 1'b0);

    redir(JUMP, 32'h0);
    tick();
    chk("jump_0", bus.pc_out, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      redir(CALL, 32'(i * 16));
      tick();
      chk("call_pc", bus.pc_out, 32'(i * 16));
      chk("call_ovf", bus.ras_overflow, (RAS && i == 5) ? 1'b1 : 1'b0);
    end

    ret_exp[0] = 32'h44;
    ret_exp[1] = 32'h34;
    ret_exp[2] = 32'h24;
    ret_exp[3] = 32'h14;
    ret_exp[4] = 32'h200;
    for (int i = 0; i < 5; i++) begin
      redir(RET, 32'h200);
      tick();
      chk("ret_pc", bus.pc_out, RAS ? ret_exp[i] : 32'h200);
      chk("ret_unf", bus.ras_underflow, (RAS && i == 4) ? 1'b1 : 1'b0);
      chk("ret_ovf", bus.ras_overflow, 1'b0);
    end
    bus.redirect_valid = 1'b0;
    tick();
    chk("after_ret_pc", bus.pc_out, 32'h204);
    chk("unf_pulse_end", bus.ras_underflow, 1'b0);

    redir(JUMP, 32'hFFFF_FFFC);
    tick();
    chk("jump_top", bus.pc_out, 32'hFFFF_FFFC);
    bus.redirect_valid = 1'b0;
    tick();
    chk("wrap", bus.pc_out, 32'h0);

    bus.enable = 1'b0;
    redir(JUMP, 32'h700);
    tick();
    chk("idle_hold", bus.pc_out, 32'h0);

    bus.enable = 1'b1;
    bus.stall = 1'b1;
    bus.trap = 1'b1;
    redir(BRANCH, 32'h80);
    tick();
    chk("trap_pc", bus.pc_out, 32'h100);
    chk("trap_ovf", bus.ras_overflow, 1'b0);
    chk("trap_unf", bus.ras_underflow, 1'b0);

    bus.trap = 1'b0;
    bus.stall = 1'b0;
    redir(CALL, 32'h500);
    tick();
    chk("call_500", bus.pc_out, 32'h500);
    bus.redirect_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_pc", bus.pc_out, 32'h0);
    chk("async_rst_valid", bus.pc_valid, 1'b0);
    tick();
    rst = 1'b1;
    redir(RET, 32'h600);
    tick();
    chk("post_rst_ret_pc", bus.pc_out, 32'h600);
    chk("post_rst_unf", bus.ras_underflow, RAS ? 1'b1 : 1'b0);
    chk("post_rst_valid", bus.pc_valid, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: PC and target width in bits.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded on reset.
REQ-003 Parameter TRAP_VECTOR, default 32'h0000_0100: PC value loaded on trap.
REQ-004 Parameter STEP, default 4: sequential increment added to the PC.
REQ-005 Parameter RAS_DEPTH, default 4: return-address-stack entries; must be at least 2.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  advance request for this cycle.
REQ-009 stall  input  1  freeze request; overrides enable.
REQ-010 redirect_valid  input  1  non-sequential update requested.
REQ-011 redirect_kind  input  2  pc_seq_pkg::redirect_e: BRANCH=0, JUMP=1, CALL=2, RET=3.
REQ-012 redirect_target  input  WIDTH  destination address for BRANCH, JUMP and CALL; fallback address for RET.
REQ-013 trap  input  1  forces PC to TRAP_VECTOR.
REQ-014 pc_out  output  WIDTH  current PC (registered).
REQ-015 pc_valid  output  1  PC is valid since reset release.
REQ-016 ras_overflow  output  1  one-cycle pulse when a push discards an entry.
REQ-017 ras_underflow  output  1  one-cycle pulse when RET is taken with the stack empty.

Function
REQ-018 Define advance = enable & ~stall; all updates take effect at the next rising edge, with one cycle of latency from input to pc_out.
REQ-019 Priority is fixed: trap > ~advance (hold) > redirect_valid > sequential.
REQ-020 When trap=1, pc_out becomes TRAP_VECTOR regardless of stall, enable or redirect; RAS contents are unchanged.
REQ-021 When advance=0 and trap=0, pc_out, the RAS and its count are held, and both flags are 0.
REQ-022 When advance=1 with no redirect, pc_out becomes (pc_out + STEP) mod 2^WIDTH; wrap-around is silent.
REQ-023 BRANCH and JUMP load redirect_target into pc_out and leave the RAS untouched.
REQ-024 CALL loads redirect_target and pushes (pc_out + STEP) mod 2^WIDTH onto the RAS.
REQ-025 A CALL with the RAS full overwrites the oldest entry (circular buffer), holds count at RAS_DEPTH, and pulses ras_overflow.
REQ-026 RET with a non-empty RAS loads the top entry into pc_out and decrements count.
REQ-027 RET with an empty RAS loads redirect_target into pc_out and pulses ras_underflow.
REQ-028 pc_valid is 0 during reset and becomes 1 at the first rising edge after rst deasserts.

Reset
REQ-029 While rst=0, immediately and asynchronously: pc_out=RESET_VECTOR, pc_valid=0, RAS count=0, RAS pointer=0, ras_overflow=0, ras_underflow=0.
REQ-030 Reset asserted mid-operation discards all RAS contents; RAS entry storage need not be reset.

Configuration
REQ-031 Macro PC_SEQ_RAS_EN compiles in the return-address stack.
REQ-032 Without PC_SEQ_RAS_EN, no RAS storage exists, CALL and RET behave exactly as JUMP, and ras_overflow and ras_underflow are tied to 0.

Structure
REQ-033 Package pc_seq_pkg holds the redirect_e enum and the RAS entry typedef.
REQ-034 The RAS is implemented as sub-module pc_ras (parameters WIDTH and RAS_DEPTH; push, pop, top, empty and full ports) and is instantiated only under PC_SEQ_RAS_EN.

Verification (defaults, macro defined)
REQ-035 Release rst, then enable=1 for 4 cycles -> pc_out sequence 0x0, 0x4, 0x8, 0xC; pc_valid=1 from the first edge after release.
REQ-036 At pc_out=0x8, stall=1 with enable=1 for 3 cycles -> pc_out holds 0x8; a BRANCH to 0x80 presented during the stall is ignored.
REQ-037 At pc_out=0x8, CALL to 0x40, then RET -> pc_out goes 0x40, then 0xC.
REQ-038 Five CALLs from 0x0, 0x10, 0x20, 0x30 and 0x40 -> ras_overflow pulses on the fifth; four RETs return 0x44, 0x34, 0x24, 0x14; a fifth RET with target 0x200 -> pc_out 0x200 and ras_underflow pulses.
REQ-039 JUMP to 0xFFFF_FFFC, then advance -> pc_out 0x0000_0000.
REQ-040 trap=1 while stall=1 -> pc_out 0x100; rst pulsed low mid-sequence -> pc_out 0x0 asynchronously, and a subsequent RET underflows.
